// File: rtl/riscv_emu_pkg.sv
// Shared types and constants for the RV32I emulation memory path.
// Imported by the memory arbiter.
package riscv_emu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_t;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } grant_t;

   localparam logic [31:0] BRAM_ADDR_MAX   = 32'h3FFF;
   localparam int          DEFAULT_TIMEOUT = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin fetch/data arbiter in front of the single-port BRAM.
// Single-cycle request pulse, watchdog error response on silence.
module mem_arbiter
   import riscv_emu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_resp,
   output logic              i_err,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_be,
   output logic [31:0]       d_rdata,
   output logic              d_resp,
   output logic              d_err,
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   output logic [3:0]        m_be,
   input  logic [31:0]       m_rdata,
   input  logic              m_resp
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   arb_state_t        state_q, state_d;
   grant_t            last_q, last_d;
   grant_t            grant_q, grant_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              wr_q, wr_d;
   logic              m_read_q, m_read_d;
   logic              m_write_q, m_write_d;
   logic              i_resp_q, i_resp_d;
   logic              i_err_q, i_err_d;
   logic [31:0]       i_rdata_q, i_rdata_d;
   logic              d_resp_q, d_resp_d;
   logic              d_err_q, d_err_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic              req_i, req_d, pick_d;
   logic              fin, fin_err;
   logic [31:0]       fin_data;

   assign req_i = i_read;
   assign req_d = d_read | d_write;

   // Next-state, grant selection, watchdog and response routing.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      wr_d      = wr_q;
      m_read_d  = 1'b0;
      m_write_d = 1'b0;
      i_resp_d  = 1'b0;
      i_err_d   = i_err_q;
      i_rdata_d = i_rdata_q;
      d_resp_d  = 1'b0;
      d_err_d   = d_err_q;
      d_rdata_d = d_rdata_q;
      pick_d    = 1'b0;
      fin       = 1'b0;
      fin_err   = 1'b0;
      fin_data  = '0;
      unique case (state_q)
         IDLE: begin
            if (req_i || req_d) begin
               pick_d = req_d && (!req_i || last_q == GRANT_I);
               if (pick_d) begin
                  grant_d = GRANT_D;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
                  be_d    = d_be;
                  wr_d    = d_write;
               end else begin
                  grant_d = GRANT_I;
                  addr_d  = i_addr;
                  wdata_d = '0;
                  be_d    = '0;
                  wr_d    = 1'b0;
               end
               last_d    = grant_d;
               m_read_d  = !wr_d;
               m_write_d = wr_d;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (m_resp) begin
               fin      = 1'b1;
               fin_data = m_rdata;
            end else if (cnt_q == TO_LAST) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
            if (fin) begin
               state_d = DONE;
               if (grant_q == GRANT_D) begin
                  d_resp_d  = 1'b1;
                  d_rdata_d = fin_data;
                  d_err_d   = fin_err;
               end else begin
                  i_resp_d  = 1'b1;
                  i_rdata_d = fin_data;
                  i_err_d   = fin_err;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, holding and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= GRANT_I;
         grant_q   <= GRANT_I;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         wr_q      <= 1'b0;
         m_read_q  <= 1'b0;
         m_write_q <= 1'b0;
         i_resp_q  <= 1'b0;
         i_err_q   <= 1'b0;
         i_rdata_q <= '0;
         d_resp_q  <= 1'b0;
         d_err_q   <= 1'b0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         wr_q      <= wr_d;
         m_read_q  <= m_read_d;
         m_write_q <= m_write_d;
         i_resp_q  <= i_resp_d;
         i_err_q   <= i_err_d;
         i_rdata_q <= i_rdata_d;
         d_resp_q  <= d_resp_d;
         d_err_q   <= d_err_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign m_read  = m_read_q;
   assign m_write = m_write_q;
   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign m_be    = be_q;
   assign i_resp  = i_resp_q;
   assign i_err   = i_err_q;
   assign i_rdata = i_rdata_q;
   assign d_resp  = d_resp_q;
   assign d_err   = d_err_q;
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 2-cycle BRAM model.
// Addresses above the BRAM range never get an answer.
`timescale 1ns/1ps
module tb_mem_arbiter;
   import riscv_emu_pkg::*;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_read, d_read, d_write;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic [31:0] i_rdata, d_rdata;
   logic        i_resp, i_err, d_resp, d_err;
   logic        m_read, m_write;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   logic        m_resp;

   logic [31:0] mem [0:4095];
   logic [31:0] pend_data;
   int          pend;
   logic        force_resp;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata),
      .i_resp(i_resp), .i_err(i_err),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_be(d_be), .d_rdata(d_rdata),
      .d_resp(d_resp), .d_err(d_err),
      .m_read(m_read), .m_write(m_write), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_be(m_be), .m_rdata(m_rdata),
      .m_resp(m_resp)
   );

   always #5 clk = ~clk;

   // BRAM model: samples the request pulse mid-cycle, answers two cycles later.
   initial begin
      m_resp    = 1'b0;
      m_rdata   = '0;
      pend      = 0;
      pend_data = '0;
      for (int k = 0; k < 4096; k++) mem[k] = '0;
      mem[0]          = 32'h00500093;
      mem[1]          = 32'hDEADBEEF;
      mem[32'h100>>2] = 32'h11223344;
      forever begin
         @(negedge clk);
         m_resp = force_resp;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               m_resp  = 1'b1;
               m_rdata = pend_data;
            end
         end
         if ((m_read || m_write) && m_addr <= BRAM_ADDR_MAX) begin
            if (m_write)
               for (int b = 0; b < 4; b++)
                  if (m_be[b])
                     mem[m_addr[13:2]][8*b +: 8] = m_wdata[8*b +: 8];
            pend_data = mem[m_addr[13:2]];
            pend      = 2;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_resp(input bit dport, output int n);
      n = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         n++;
         if (dport ? d_resp : i_resp) break;
      end
   endtask

   task automatic wait_any(output logic wi, output logic wd, output int n);
      n  = 0;
      wi = 1'b0;
      wd = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick();
         n++;
         if (i_resp || d_resp) begin
            wi = i_resp;
            wd = d_resp;
            break;
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".m_rd"}, {31'b0, m_read}, 32'd0);
      chk({tag, ".m_wr"}, {31'b0, m_write}, 32'd0);
      chk({tag, ".m_addr"}, m_addr, 32'd0);
      chk({tag, ".i_rsp"}, {31'b0, i_resp}, 32'd0);
      chk({tag, ".i_rdat"}, i_rdata, 32'd0);
      chk({tag, ".d_rsp"}, {31'b0, d_resp}, 32'd0);
      chk({tag, ".d_rdat"}, d_rdata, 32'd0);
   endtask

   initial begin
      int   n;
      logic wi, wd;
      rst_n = 1'b0; force_resp = 1'b0;
      i_read = 0; i_addr = 0; d_read = 0; d_write = 0;
      d_addr = 0; d_wdata = 0; d_be = 0;
      repeat (3) tick();
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      // fetch only
      i_read = 1; i_addr = 32'h0;
      tick();
      chk("f.m_read", {31'b0, m_read}, 32'd1);
      chk("f.m_write", {31'b0, m_write}, 32'd0);
      chk("f.m_addr", m_addr, 32'h0);
      tick();
      chk("f.pulse", {31'b0, m_read}, 32'd0);
      wait_resp(0, n);
      chk("f.lat", n + 2, 4);
      chk("f.rdata", i_rdata, 32'h00500093);
      chk("f.err", {31'b0, i_err}, 32'd0);
      chk("f.d_resp", {31'b0, d_resp}, 32'd0);
      i_read = 0;
      tick();
      chk("f.resp1cyc", {31'b0, i_resp}, 32'd0);
      chk("f.hold", i_rdata, 32'h00500093);

      // store
      d_write = 1; d_addr = 32'h100; d_wdata = 32'hAABBCCDD; d_be = 4'b0010;
      tick();
      chk("st.m_write", {31'b0, m_write}, 32'd1);
      chk("st.m_read", {31'b0, m_read}, 32'd0);
      chk("st.m_be", {28'b0, m_be}, 32'h2);
      chk("st.m_wdata", m_wdata, 32'hAABBCCDD);
      chk("st.m_addr", m_addr, 32'h100);
      wait_resp(1, n);
      chk("st.lat", n + 1, 4);
      chk("st.err", {31'b0, d_err}, 32'd0);
      d_write = 0;
      tick();

      // load back
      d_read = 1; d_addr = 32'h100;
      tick();
      chk("ld.m_read", {31'b0, m_read}, 32'd1);
      wait_resp(1, n);
      chk("ld.lat", n + 1, 4);
      chk("ld.rdata", d_rdata, 32'h1122CC44);
      d_read = 0;
      tick();

      // read+write together: the write wins
      d_read = 1; d_write = 1; d_addr = 32'h200;
      d_wdata = 32'h01020304; d_be = 4'hF;
      tick();
      chk("rw.m_write", {31'b0, m_write}, 32'd1);
      chk("rw.m_read", {31'b0, m_read}, 32'd0);
      wait_resp(1, n);
      chk("rw.lat", n + 1, 4);
      d_read = 0; d_write = 0;
      tick();

      // contention from reset
      rst_n = 1'b0;
      i_read = 1; i_addr = 32'h0; d_read = 1; d_addr = 32'h100;
      tick();
      rst_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         wait_any(wi, wd, n);
         chk($sformatf("ct%0d.grant", t), {30'b0, wi, wd},
             (t % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("ct%0d.gap", t), n, (t == 0) ? 4 : 5);
         if (t % 2 == 0)
            chk($sformatf("ct%0d.d", t), d_rdata, 32'h1122CC44);
         else
            chk($sformatf("ct%0d.i", t), i_rdata, 32'h00500093);
      end
      i_read = 0; d_read = 0;
      tick();
      chk("ct.i1cyc", {31'b0, i_resp}, 32'd0);

      // timeout on out-of-range address
      d_read = 1; d_addr = 32'h4000;
      tick();
      chk("to.m_read", {31'b0, m_read}, 32'd1);
      wait_resp(1, n);
      chk("to.lat", n + 1, 2 + TO);
      chk("to.err", {31'b0, d_err}, 32'd1);
      chk("to.rdata", d_rdata, 32'd0);
      d_read = 0;
      tick();
      i_read = 1; i_addr = 32'h0;
      wait_resp(0, n);
      chk("to.i_lat", n, 4);
      chk("to.i_err", {31'b0, i_err}, 32'd0);
      chk("to.i_rdata", i_rdata, 32'h00500093);
      i_read = 0;
      tick();

      // reset in the middle of WAIT
      i_read = 1; i_addr = 32'h4;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk_zero("rstw");
      i_read = 0;
      tick();
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (i_resp || d_resp) n++;
      end
      chk("rstw.noresp", n, 0);
      i_read = 1; i_addr = 32'h4;
      wait_resp(0, n);
      chk("rstw.lat", n, 4);
      chk("rstw.rdata", i_rdata, 32'hDEADBEEF);
      i_read = 0;
      tick();

      // stray m_resp while idle
      force_resp = 1;
      tick();
      force_resp = 0;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (i_resp || d_resp || m_read || m_write) n++;
      end
      chk("stray.quiet", n, 0);
      i_read = 1; i_addr = 32'h0;
      wait_resp(0, n);
      chk("stray.lat", n, 4);
      chk("stray.err", {31'b0, i_err}, 32'd0);
      i_read = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
